// File: rtl/param_updown_counter.sv
// Synchronous parametrised up/down counter with modulus, parallel load,
// synchronous clear, wrap/saturate bounds, terminal-count pulse and sticky flags.
module param_updown_counter #(
   parameter int WIDTH    = 4,
   parameter int MAX_VAL  = (1 << WIDTH) - 1,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up_down,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf,
   output logic             unf
);

   // One extra bit so the bound compare and the +1 step never overflow.
   localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

   logic [WIDTH:0]   q_ext;
   logic [WIDTH:0]   load_ext;
   logic [WIDTH:0]   step_ext;
   logic             at_max;
   logic             at_min;
   logic [WIDTH-1:0] q_next;
   logic             tc_next;
   logic             ovf_next;
   logic             unf_next;

   assign q_ext    = {1'b0, q};
   assign load_ext = {1'b0, load_val};
   assign at_max   = (q_ext >= MAX_EXT);
   assign at_min   = (q_ext == '0);

   always_comb begin
      step_ext = q_ext;
      tc_next  = 1'b0;
      // clr_flags drops the sticky flags unless an event on this edge sets them again
      ovf_next = ovf & ~clr_flags;
      unf_next = unf & ~clr_flags;
      if (sclr) begin
         step_ext = '0;
         ovf_next = 1'b0;
         unf_next = 1'b0;
      end else if (load) begin
         step_ext = (load_ext > MAX_EXT) ? MAX_EXT : load_ext;
      end else if (en) begin
         if (up_down) begin
            if (at_max) begin
               tc_next  = 1'b1;
               ovf_next = 1'b1;
               step_ext = SATURATE ? q_ext : '0;
            end else begin
               step_ext = q_ext + ONE_EXT;
            end
         end else begin
            if (at_min) begin
               tc_next  = 1'b1;
               unf_next = 1'b1;
               step_ext = SATURATE ? q_ext : MAX_EXT;
            end else begin
               step_ext = q_ext - ONE_EXT;
            end
         end
      end
      q_next = step_ext[WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q   <= '0;
         tc  <= 1'b0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         q   <= q_next;
         tc  <= tc_next;
         ovf <= ovf_next;
         unf <= unf_next;
      end
   end

endmodule
